// File: rtl/zero_step_controller_if.sv
// rtl/zero_step_controller_if.sv - issue/done/drain handshake bundle for zero_step_controller
// master = controller side, slave = instruction datapath plus out-value consumer.
interface zero_step_controller_if #(
    parameter int MemoryElementWidth = 12,
    parameter int IpWidth            = 12
);
    logic                          execValid;
    logic [IpWidth-1:0]            execIp;
    logic                          execReady;
    logic                          doneValid;
    logic [IpWidth-1:0]            nextIp;
    logic                          outValid;
    logic [MemoryElementWidth-1:0] outData;
    logic                          drainValid;
    logic [MemoryElementWidth-1:0] drainData;
    logic                          drainReady;

    modport master (
        output execValid, execIp, drainValid, drainData,
        input  execReady, doneValid, nextIp, outValid, outData, drainReady
    );

    modport slave (
        input  execValid, execIp, drainValid, drainData,
        output execReady, doneValid, nextIp, outValid, outData, drainReady
    );
endinterface

// File: rtl/zero_step_controller.sv
// rtl/zero_step_controller.sv - sequences a zero program: issues ips, counts steps, buffers out values
// Optional step limit enabled by defining ZERO_STEP_LIMIT_EN.
module zero_step_controller #(
    parameter int MemoryElementWidth = 12,
    parameter int IpWidth            = 12,
    parameter int NInstructions      = 2,
    parameter int NOut               = 4,
    parameter int MaxSteps           = 1000
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         run,
    zero_step_controller_if.master       bus,
    output logic                         finished,
    output logic                         success,
    output logic [31:0]                  steps,
    output logic                         overflow,
    output logic                         timeout
);
    localparam int PtrW = $clog2(NOut);
    localparam int CntW = PtrW + 1;
    localparam logic [IpWidth-1:0] EndIp   = IpWidth'(NInstructions);
    localparam logic [CntW-1:0]    FullCnt = CntW'(NOut);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HALT} state_t;

    state_t                        state_q, state_d;
    logic [IpWidth-1:0]            ip_q, ip_d;
    logic [31:0]                   steps_q, steps_d;
    logic                          overflow_q, overflow_d;
    logic                          timeout_q, timeout_d;
    logic                          run_q;
    logic [PtrW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]               count_q;
    logic [MemoryElementWidth-1:0] mem_q [NOut];

    logic run_rise, limit_hit, exec_valid, clear_fifo;
    logic push_req, push, pop, full, fifo_nonempty;

    assign run_rise      = run && !run_q;
    assign fifo_nonempty = (count_q != '0);
    assign full          = (count_q == FullCnt);
    assign pop           = fifo_nonempty && bus.drainReady;
    assign push_req      = (state_q == S_WAIT) && bus.doneValid && bus.outValid;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push          = push_req && (!full || pop);

`ifdef ZERO_STEP_LIMIT_EN
    localparam logic [31:0] StepLimit = 32'(MaxSteps);
    assign limit_hit = (steps_q == StepLimit);
`else
    logic unused_max_steps;
    assign unused_max_steps = ^(32'(MaxSteps));
    assign limit_hit        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ip_d       = ip_q;
        steps_d    = steps_q;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;
        exec_valid = 1'b0;
        clear_fifo = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (run_rise) begin
                    state_d    = S_ISSUE;
                    ip_d       = '0;
                    steps_d    = '0;
                    overflow_d = 1'b0;
                    timeout_d  = 1'b0;
                    clear_fifo = 1'b1;
                end
            end
            S_ISSUE: begin
                if (limit_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else if (ip_q >= EndIp) begin
                    state_d = S_HALT;
                end else begin
                    exec_valid = 1'b1;
                    if (bus.execReady) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.doneValid) begin
                    steps_d = steps_q + 32'd1;
                    ip_d    = bus.nextIp;
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (push_req && full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_IDLE;
            ip_q       <= '0;
            steps_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ip_q       <= ip_d;
            steps_q    <= steps_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            run_q      <= run;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_fifo) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= bus.outData;
    end

    assign bus.execValid  = exec_valid;
    assign bus.execIp     = exec_valid ? ip_q : '0;
    assign bus.drainValid = fifo_nonempty;
    assign bus.drainData  = fifo_nonempty ? mem_q[rd_ptr_q] : '0;
    assign finished       = (state_q == S_HALT) && !fifo_nonempty;
    assign success        = finished && !overflow_q && !timeout_q;
    assign steps          = steps_q;
    assign overflow       = overflow_q;
    assign timeout        = timeout_q;
endmodule
